phase_sweep: RTL and testbench
==============================

# phase_sweep

Phase generator feeding the sincos CORDIC stage. A start strobe latches a phase increment, an optional chirp (increment slope), a sample count and a sample-rate divider. The block then emits a stream of wrapped phase words in 1.2.5 radian format with a valid strobe. The phase output drives the CORDIC phase input and the valid strobe drives its enable, one word per strobe.

## Interface
- PW, 8: output phase width, 1.2.(PW-3) signed radians.
- AW, 16: accumulator, step and chirp width, 1.2.(AW-3) signed radians.
- CW, 16: sample count width.
- DW, 8: divider width.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin sweep. Sampled only in IDLE.
- stop  in  1  abort sweep.
- step  in  AW  signed phase increment per sample. Latched at start.
- chirp  in  AW  signed increment added to step after each sample. Latched at start.
- count  in  CW  samples to emit; 0 = continuous until stop.
- div  in  DW  sample period minus 1, in clocks. Latched at start.
- phase  out  PW  phase word, registered.
- phase_valid  out  1  phase is a new sample (drives CORDIC enable).
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse after the last sample of a counted sweep.

## Operation
- Constants:
  - PI_FX = floor(pi·2^(AW-3)) = 25735 for AW=16.
  - TWO_PI_FX = 2·PI_FX = 51470.
  - PI_OUT = floor(pi·2^(PW-3)) = 100 for PW=8.
- States:
  - IDLE: waits for start.
  - RUN: emits samples.
  - DONE: one cycle; done=1; returns to IDLE.
- IDLE, start=1, stop=0:
  - Latch div and count.
  - Latch step into cur_step, clamped to [-PI_FX, PI_FX].
  - Latch chirp.
  - Clear acc, divider counter and sample counter.
  - Go to RUN.
- IDLE, start=1 and stop=1: stop wins; stay in IDLE.
- RUN, on each divider tick (divider counter == 0):
  - phase ← sat(acc >>> (AW-PW)), saturated to [-PI_OUT, PI_OUT]; phase_valid ← 1.
  - acc ← wrap(acc + cur_step).
  - cur_step ← clamp(cur_step + chirp, ±PI_FX).
  - Sample counter increments.
  - Divider counter reloads to div; it decrements on non-tick cycles.
- wrap(s): compute s at AW+1 bits.
  - If s ≥ PI_FX: s − TWO_PI_FX.
  - Else if s < −PI_FX: s + TWO_PI_FX.
  - Result is always in [−PI_FX, PI_FX); one correction suffices because |cur_step| ≤ PI_FX.
- When count ≠ 0 and the tick emits sample number count: next state DONE.
- count = 0: the sample counter wraps freely and DONE is never reached.
- stop in RUN: next state IDLE. No further phase_valid, no done. The stop cycle's own tick is suppressed.
- start while in RUN or DONE: ignored.
- Step and chirp clamping saturate; they never wrap.

## Timing
- Reset: state IDLE; phase=0, phase_valid=0, busy=0, done=0; acc, cur_step and all counters cleared.
- rst mid-sweep aborts on the next edge with no done pulse. rst overrides start and stop.
- First sample: phase_valid=1 with phase=0 in the first cycle after the start edge.
- Later samples every div+1 cycles. div=0 gives back-to-back valid.
- phase_valid is high exactly one cycle per sample. phase holds its value between samples.
- busy=1 from the first RUN cycle through the cycle carrying the last phase_valid.
- done=1 in the cycle after the last phase_valid, with busy=0.
- A new start is accepted the cycle after done, at the earliest.
- Latency from accumulator to output: 1 cycle (registered output).

## Structure
- Shared package/include phase_pkg:
  - PI_FX, TWO_PI_FX and PI_OUT as functions of AW and PW.
  - State encoding IDLE/RUN/DONE.
- Sub-module phase_wrap: combinational AW-bit add plus single-step ±TWO_PI_FX correction. Reused by any other accumulator feeding the CORDIC.

## Test plan
All cases use AW=16, PW=8.
- step=8192, chirp=0, div=0, count=4: phase_valid high 4 consecutive cycles; phase 0, 32, 64, 96; done on the 5th cycle; busy low.
- Same with count=5: 5th phase = −74. acc 32768 wraps to −18702; −18702 >>> 8 = −74.
- step=−25735, count=2: phases 0 then −100 (−101 saturated). step=30000 is clamped to 25735 at latch.
- step=8192, div=3, count=3: phase_valid at cycles 1, 5 and 9 after start; no valid in between; phase holds.
- step=0, chirp=256, count=4: phases 0, 0, 1, 3.
- Aborts and simultaneous events:
  - count=0, stop asserted after 3 samples: no further valid; done never pulses.
  - start and stop together in IDLE: no sweep starts.
  - rst asserted mid-run: all outputs 0 on the next cycle.

Source files
------------

// File: rtl/phase_pkg.sv
// Shared constants and state encoding for the phase generators feeding the sincos CORDIC.
// Fixed-point pi values are derived from a 32-fraction-bit pi so any AW/PW up to 35 works.
package phase_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // floor(pi * 2^32)
    localparam longint PI_Q32 = 64'd13493037704;

    // floor(pi * 2^(w-3)) for a 1.2.(w-3) radian word
    function automatic longint pi_fx(input int w);
        return PI_Q32 >>> (35 - w);
    endfunction

    function automatic longint two_pi_fx(input int w);
        return 2 * pi_fx(w);
    endfunction

    function automatic longint pi_out(input int w);
        return pi_fx(w);
    endfunction

endpackage

// File: rtl/phase_wrap.sv
// Phase accumulator adder: a + b folded back into [-pi, pi) with one 2*pi correction.
// Inputs must satisfy |a| <= pi and |b| <= pi so a single correction is enough.
module phase_wrap
    import phase_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic signed [AW-1:0] a,
    input  logic signed [AW-1:0] b,
    output logic signed [AW-1:0] y
);

    localparam longint PI_L  = pi_fx(AW);
    localparam longint TWO_L = two_pi_fx(AW);
    localparam logic signed [AW:0]   PI_X  = PI_L[AW:0];
    localparam logic signed [AW:0]   NPI_X = -PI_X;
    localparam logic signed [AW-1:0] TWO_W = TWO_L[AW-1:0];

    logic signed [AW:0] s;

    // The range decision needs the extra bit; the corrected sum itself fits AW bits,
    // so the correction is applied modulo 2^AW.
    always_comb begin
        s = {a[AW-1], a} + {b[AW-1], b};
        if (s >= PI_X)
            y = a + b - TWO_W;
        else if (s < NPI_X)
            y = a + b + TWO_W;
        else
            y = a + b;
    end

endmodule

// File: rtl/phase_sweep.sv
// Chirped phase sweep generator: emits wrapped 1.2.(PW-3) phase words with a valid strobe.
// The start edge itself emits sample 0, so the first valid appears the cycle after start.
module phase_sweep
    import phase_pkg::*;
#(
    parameter int PW = 8,
    parameter int AW = 16,
    parameter int CW = 16,
    parameter int DW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic signed [AW-1:0] step,
    input  logic signed [AW-1:0] chirp,
    input  logic [CW-1:0]        count,
    input  logic [DW-1:0]        div,
    output logic signed [PW-1:0] phase,
    output logic                 phase_valid,
    output logic                 busy,
    output logic                 done
);

    localparam longint PI_L = pi_fx(AW);
    localparam longint PO_L = pi_out(PW);
    localparam logic signed [AW:0]   PI_X  = PI_L[AW:0];
    localparam logic signed [AW:0]   NPI_X = -PI_X;
    localparam logic signed [AW-1:0] PO_X  = PO_L[AW-1:0];
    localparam logic signed [AW-1:0] NPO_X = -PO_X;

    state_t state, state_nx;

    logic signed [AW-1:0] acc, cur_step, chirp_q;
    logic [CW-1:0]        count_q, smp;
    logic [DW-1:0]        div_q, divcnt;

    logic                 launch, tick, emit, last;
    logic signed [AW-1:0] src_acc, src_step, src_chirp, acc_nx, step_nx, sh;
    logic [CW-1:0]        src_smp, src_cnt, smp_nx;
    logic [DW-1:0]        src_div;
    logic signed [PW-1:0] phase_nx;

    function automatic logic signed [AW-1:0] clamp_step(input logic signed [AW:0] v);
        if (v > PI_X)
            return PI_X[AW-1:0];
        else if (v < NPI_X)
            return NPI_X[AW-1:0];
        else
            return v[AW-1:0];
    endfunction

    // A launch acts like a tick on freshly latched values, so one datapath serves both.
    always_comb begin
        launch    = (state == IDLE) && start && !stop && !done;
        tick      = (state == RUN) && (divcnt == '0) && !stop;
        emit      = launch || tick;
        src_acc   = launch ? '0 : acc;
        src_step  = launch ? clamp_step({step[AW-1], step}) : cur_step;
        src_chirp = launch ? chirp : chirp_q;
        src_smp   = launch ? '0 : smp;
        src_cnt   = launch ? count : count_q;
        src_div   = launch ? div : div_q;
        smp_nx    = src_smp + 1'b1;
        last      = (src_cnt != '0) && (smp_nx == src_cnt);
        step_nx   = clamp_step({src_step[AW-1], src_step} + {src_chirp[AW-1], src_chirp});
        sh        = src_acc >>> (AW - PW);
        if (sh > PO_X)
            phase_nx = PO_X[PW-1:0];
        else if (sh < NPO_X)
            phase_nx = NPO_X[PW-1:0];
        else
            phase_nx = sh[PW-1:0];
    end

    phase_wrap #(.AW(AW)) u_wrap (
        .a (src_acc),
        .b (src_step),
        .y (acc_nx)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (launch) state_nx = last ? DONE : RUN;
            RUN: begin
                if (stop)
                    state_nx = IDLE;
                else if (tick && last)
                    state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            phase       <= '0;
            phase_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            acc         <= '0;
            cur_step    <= '0;
            chirp_q     <= '0;
            count_q     <= '0;
            div_q       <= '0;
            smp         <= '0;
            divcnt      <= '0;
        end else begin
            state       <= state_nx;
            phase_valid <= emit;
            busy        <= (state_nx != IDLE);
            done        <= (state == DONE);
            if (launch) begin
                chirp_q <= chirp;
                count_q <= count;
                div_q   <= div;
            end
            if (emit) begin
                phase    <= phase_nx;
                acc      <= acc_nx;
                cur_step <= step_nx;
                smp      <= smp_nx;
                divcnt   <= src_div;
            end else if (state == RUN && !stop) begin
                divcnt   <= divcnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_phase_sweep.sv
// Self-checking bench for phase_sweep: table of spec vectors, random sweeps against an
// integer reference model, and hand-written abort/reset sequences.
module tb_phase_sweep;

    localparam int PI  = 25735;
    localparam int TPI = 51470;
    localparam int PO  = 100;

    logic               clk = 1'b0;
    logic               rst, start, stop;
    logic signed [15:0] step, chirp;
    logic [15:0]        count;
    logic [7:0]         div;
    logic signed [7:0]  phase;
    logic               phase_valid, busy, done;

    int tests = 0;
    int fails = 0;

    phase_sweep #(.PW(8), .AW(16), .CW(16), .DW(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .step        (step),
        .chirp       (chirp),
        .count       (count),
        .div         (div),
        .phase       (phase),
        .phase_valid (phase_valid),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string nm;
        int    st, ch, cn, dv;
        int    exp[5];
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    function automatic int clampi(input int v);
        if (v > PI)  return PI;
        if (v < -PI) return -PI;
        return v;
    endfunction

    // Expected phase list straight from the arithmetic rules: wrap into [-pi, pi), floor-scale
    // to the output format, saturate to +-PI_OUT.
    function automatic void model(input int st, input int ch, input int cn, output int q[$]);
        int a, s, p;
        q = {};
        a = 0;
        s = clampi(st);
        for (int k = 0; k < cn; k++) begin
            p = a >>> 8;
            if (p > PO)  p = PO;
            if (p < -PO) p = -PO;
            q.push_back(p);
            a = a + s;
            if (a >= PI)      a = a - TPI;
            else if (a < -PI) a = a + TPI;
            s = clampi(s + ch);
        end
    endfunction

    task automatic setv(input int i, input string nm, input int st, input int ch, input int cn,
                        input int dv, input int e0, input int e1, input int e2, input int e3,
                        input int e4);
        vecs[i].nm  = nm;
        vecs[i].st  = st;
        vecs[i].ch  = ch;
        vecs[i].cn  = cn;
        vecs[i].dv  = dv;
        vecs[i].exp = '{e0, e1, e2, e3, e4};
    endtask

    // Run one counted sweep and check every output on every cycle until done has cleared.
    task automatic run_sweep(input string nm, input int st, input int ch, input int cn,
                             input int dv, input int exp[$]);
        int per, last, k;
        per  = dv + 1;
        last = 1 + (cn - 1) * per;
        @(negedge clk);
        step  = 16'(st);
        chirp = 16'(ch);
        count = 16'(cn);
        div   = 8'(dv);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= last + 2; c++) begin
            k = (c <= last) ? (c - 1) / per : cn - 1;
            chk({nm, " valid"}, int'(phase_valid), int'((c <= last) && ((c - 1) % per == 0)));
            chk({nm, " busy"},  int'(busy), int'(c <= last));
            chk({nm, " done"},  int'(done), int'(c == last + 1));
            chk({nm, " phase"}, int'(phase), exp[k]);
            @(negedge clk);
        end
    endtask

    initial begin
        int q[$];
        int st, ch, cn, dv;

        rst = 1'b1; start = 1'b0; stop = 1'b0;
        step = '0; chirp = '0; count = '0; div = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset phase", int'(phase), 0);
        chk("reset valid", int'(phase_valid), 0);
        chk("reset busy",  int'(busy), 0);
        chk("reset done",  int'(done), 0);

        setv(0, "ramp4",   8192,   0,   4, 0, 0, 32,   64, 96, 0);
        setv(1, "ramp5",   8192,   0,   5, 0, 0, 32,   64, 96, -74);
        setv(2, "negpi",  -25735,  0,   2, 0, 0, -100, 0,  0,  0);
        setv(3, "clamp",   30000,  0,   2, 0, 0, -100, 0,  0,  0);
        setv(4, "div3",    8192,   0,   3, 3, 0, 32,   64, 0,  0);
        setv(5, "chirp",   0,      256, 4, 0, 0, 0,    1,  3,  0);
        foreach (vecs[i]) begin
            q = {};
            for (int j = 0; j < vecs[i].cn; j++) q.push_back(vecs[i].exp[j]);
            run_sweep(vecs[i].nm, vecs[i].st, vecs[i].ch, vecs[i].cn, vecs[i].dv, q);
        end

        for (int r = 0; r < 25; r++) begin
            st = int'($urandom_range(0, 65535)) - 32768;
            ch = (r % 3 == 0) ? int'($urandom_range(0, 65535)) - 32768
                              : int'($urandom_range(0, 8000)) - 4000;
            cn = int'($urandom_range(1, 6));
            dv = int'($urandom_range(0, 3));
            model(st, ch, cn, q);
            run_sweep("rand", st, ch, cn, dv, q);
        end

        // start and stop together in IDLE: stop wins
        @(negedge clk);
        step = 16'(8192); chirp = '0; count = 16'(3); div = '0;
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("startstop valid", int'(phase_valid), 0);
            chk("startstop busy",  int'(busy), 0);
            @(negedge clk);
        end

        // continuous sweep aborted by stop after three samples
        step = 16'(8192); chirp = '0; count = '0; div = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("cont s0", int'(phase), 0);
        @(negedge clk);
        chk("cont s1", int'(phase), 32);
        @(negedge clk);
        chk("cont s2", int'(phase), 64);
        chk("cont busy", int'(busy), 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        for (int c = 0; c < 6; c++) begin
            chk("stop valid", int'(phase_valid), 0);
            chk("stop busy",  int'(busy), 0);
            chk("stop done",  int'(done), 0);
            chk("stop hold",  int'(phase), 64);
            @(negedge clk);
        end

        // reset in the middle of a continuous sweep
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst phase", int'(phase), 0);
        chk("midrst valid", int'(phase_valid), 0);
        chk("midrst busy",  int'(busy), 0);
        chk("midrst done",  int'(done), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst idle", int'(phase_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
